serial_word_collector: RTL and testbench

- Receiving end of the gated-pulse serial bus: collects bit-time pulses produced by the clocked AND-gate network and assembles them into parallel LVDC words, LSB first.
- Feeds the parallel word to downstream register and arithmetic models through a valid/ack handshake.
- The output word register is double-buffered, so the next word assembles while the previous one waits for ack.

---
 rtl/serial_word_collector.sv | 210 +++++++++++++++++++++
 tb/tb_serial_word_collector.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_word_collector.sv
// ---------------------------------------------------------------------------
// serial_word_collector
//
// Receiving end of the gated-pulse serial bus. Bit-time pulses arrive LSB
// first, one per bit_strobe, and are assembled into a WIDTH-bit word. The
// first bit of a word is marked by sync. Completed words go to a
// valid/ack-handshaked output register. Because the shift register is
// separate from that output register, the next word can assemble while the
// previous one waits for ack.
//
// Optional feature (compile-time macro PARITY_CHECK_EN):
//   When defined, one odd-parity bit time follows the WIDTH data bits. That
//   bit is checked but is not stored in word. parity_err reports the result.
//   When undefined, parity_err is tied to 0.
//
// Parameters:
//   WIDTH  data bits per word (2..31)
//   IV     reset value of the word output register
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   bit_strobe  one-cycle bit-time strobe; pulse and sync are sampled only
//               when it is high
//   pulse       serial data bit (1 = pulse present)
//   sync        marks the current strobe as bit 0 of a new word
//   ack         consumer accepts word; clears valid
//   word        last completed word; bit 0 is the first bit received
//   valid       word holds an unconsumed completed word
//   parity_err  parity result for the word currently in word
//   overrun     sticky: a completed word was dropped while valid was set
//   frame_err   sticky: sync arrived in the middle of a word
//   bit_count   number of bits collected in the current word
// ---------------------------------------------------------------------------
module serial_word_collector #(
    parameter int          WIDTH = 26,
    parameter int unsigned IV    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_strobe,
    input  logic             pulse,
    input  logic             sync,
    input  logic             ack,
    output logic [WIDTH-1:0] word,
    output logic             valid,
    output logic             parity_err,
    output logic             overrun,
    output logic             frame_err,
    output logic [4:0]       bit_count
);

`ifdef PARITY_CHECK_EN
    // N bit times per word. The shift register holds all WIDTH data bits.
    // The parity bit is consumed directly from pulse on the final strobe.
    localparam int N    = WIDTH + 1;
    localparam int SR_W = WIDTH;
`else
    // The final data bit is taken straight from pulse on the completing
    // strobe, so only WIDTH-1 bits need to be held.
    localparam int N    = WIDTH;
    localparam int SR_W = WIDTH - 1;
`endif

    localparam logic [WIDTH-1:0] IV_W     = WIDTH'(IV);
    localparam logic [4:0]       LAST_CNT = 5'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [SR_W-1:0]   sr, sr_n;
    logic [4:0]        cnt, cnt_n;
    logic [WIDTH-1:0]  word_q, word_n;
    logic              valid_q, valid_n;
    logic              ovr_q, ovr_n;
    logic              ferr_q, ferr_n;

    // Value of sr after the current strobe, and the value it takes when
    // this strobe is bit 0 of a word. New bits enter at the top, so after
    // SR_W strobes the first bit has reached position 0.
    logic [SR_W-1:0]   sr_shifted;
    logic [SR_W-1:0]   sr_first;

    // Word completion for the current cycle
    logic              done;
    logic [WIDTH-1:0]  new_word;

`ifdef PARITY_CHECK_EN
    logic              perr_q, perr_n;
    logic              new_perr;
`endif

    assign sr_shifted = (sr >> 1) | (SR_W'(pulse) << (SR_W - 1));
    assign sr_first   = SR_W'(pulse) << (SR_W - 1);

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sr      <= '0;
            cnt     <= '0;
            word_q  <= IV_W;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state   <= state_n;
            sr      <= sr_n;
            cnt     <= cnt_n;
            word_q  <= word_n;
            valid_q <= valid_n;
            ovr_q   <= ovr_n;
            ferr_q  <= ferr_n;
        end
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) perr_q <= 1'b0;
        else     perr_q <= perr_n;
    end
`endif

    // ---------------------------------------------------------------------
    // Next-state logic: collection FSM plus the output handshake
    // ---------------------------------------------------------------------
    always_comb begin
        state_n  = state;
        sr_n     = sr;
        cnt_n    = cnt;
        word_n   = word_q;
        valid_n  = valid_q;
        ovr_n    = ovr_q;
        ferr_n   = ferr_q;
        done     = 1'b0;
`ifdef PARITY_CHECK_EN
        perr_n   = perr_q;
        new_perr = ~((^sr) ^ pulse);
        new_word = sr;
`else
        new_word = {pulse, sr};
`endif

        case (state)
            IDLE: begin
                // Strobes without sync are ignored while idle
                if (bit_strobe && sync) begin
                    sr_n    = sr_first;
                    cnt_n   = 5'd1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_strobe) begin
                    if (sync) begin
                        // A sync in mid-word aborts the partial word.
                        // This strobe becomes bit 0 of a fresh word.
                        sr_n   = sr_first;
                        cnt_n  = 5'd1;
                        ferr_n = 1'b1;
                    end else if (cnt == LAST_CNT) begin
                        done    = 1'b1;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        sr_n  = sr_shifted;
                        cnt_n = cnt + 5'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // Output register. An ack in the same cycle as a completion frees
        // the slot, so the new word is loaded and valid stays set.
        if (done) begin
            if (!valid_q || ack) begin
                word_n  = new_word;
                valid_n = 1'b1;
`ifdef PARITY_CHECK_EN
                perr_n  = new_perr;
`endif
            end else begin
                ovr_n = 1'b1;
            end
        end else if (ack && valid_q) begin
            valid_n = 1'b0;
        end
    end

    assign word      = word_q;
    assign valid     = valid_q;
    assign overrun   = ovr_q;
    assign frame_err = ferr_q;
    assign bit_count = cnt;
`ifdef PARITY_CHECK_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_collector.sv
module tb_serial_word_collector;

    localparam int WIDTH = 26;
    localparam int IV    = 0;
`ifdef PARITY_CHECK_EN
    localparam int NB  = WIDTH + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int NB  = WIDTH;
    localparam bit PAR = 1'b0;
`endif
    localparam logic [31:0] MASK = (32'h1 << WIDTH) - 32'h1;

    logic             clk = 1'b0;
    logic             rst;
    logic             bit_strobe, pulse, sync, ack;
    logic [WIDTH-1:0] word;
    logic             valid, parity_err, overrun, frame_err;
    logic [4:0]       bit_count;

    int tests = 0;
    int fails = 0;

    // Transaction-level reference state
    logic [31:0] exp_word;
    logic        exp_valid, exp_perr, exp_ovr, exp_ferr;

    serial_word_collector #(.WIDTH(WIDTH), .IV(IV)) dut (
        .clk(clk), .rst(rst), .bit_strobe(bit_strobe), .pulse(pulse),
        .sync(sync), .ack(ack), .word(word), .valid(valid),
        .parity_err(parity_err), .overrun(overrun), .frame_err(frame_err),
        .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h required %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int exp_cnt);
        check({tag, ".word"},  32'(word), exp_word);
        check({tag, ".valid"}, 32'(valid), 32'(exp_valid));
        check({tag, ".perr"},  32'(parity_err), 32'(exp_perr));
        check({tag, ".ovr"},   32'(overrun), 32'(exp_ovr));
        check({tag, ".ferr"},  32'(frame_err), 32'(exp_ferr));
        check({tag, ".cnt"},   32'(bit_count), 32'(exp_cnt));
    endtask

    task automatic model_reset();
        exp_word  = 32'(IV) & MASK;
        exp_valid = 1'b0;
        exp_perr  = 1'b0;
        exp_ovr   = 1'b0;
        exp_ferr  = 1'b0;
    endtask

    task automatic strobe(input logic p, input logic s, input logic a);
        @(negedge clk);
        bit_strobe = 1'b1; pulse = p; sync = s; ack = a;
        @(posedge clk); #1;
        bit_strobe = 1'b0; pulse = 1'b0; sync = 1'b0; ack = 1'b0;
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        if (exp_valid) exp_valid = 1'b0;
    endtask

    // Send a full word LSB first, with sync on bit 0 and random idle gaps.
    // When parity is enabled, the parity bit is odd parity over data,
    // inverted if flip is set. The last strobe is left open long enough
    // to confirm that valid has not yet changed.
    task automatic send_word(input logic [31:0] data, input logic a_last,
                             input int gap_max, input logic flip);
        logic b;
        logic parbit;
        parbit = (~^(data & MASK)) ^ flip;
        for (int i = 0; i < NB; i++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            b = (i < WIDTH) ? data[i] : parbit;
            if (i < NB - 1) begin
                strobe(b, i == 0, 1'b0);
            end else begin
                @(negedge clk);
                bit_strobe = 1'b1; pulse = b; sync = 1'b0; ack = a_last;
                check("pre_valid", 32'(valid), 32'(exp_valid));
                @(posedge clk); #1;
                bit_strobe = 1'b0; pulse = 1'b0; ack = 1'b0;
            end
        end
        if (!exp_valid || a_last) begin
            exp_word  = data & MASK;
            exp_valid = 1'b1;
            exp_perr  = PAR && (((^(data & MASK)) ^ parbit) == 1'b0);
        end else begin
            exp_ovr = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;
        logic        a;
        logic        f;
        rst = 1'b1; bit_strobe = 1'b0; pulse = 1'b0; sync = 1'b0; ack = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset", 0);
        rst = 1'b0;

        // Strobes without sync while idle are ignored
        for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check_all("idle_nosync", 0);

        // Basic word, one cycle latency
        send_word(32'h2AAAAAA, 1'b0, 0, 1'b0);
        check_all("basic", 0);

        // Ack coincident with completion loads the new word, no overrun
        send_word(32'h1234567, 1'b1, 1, 1'b0);
        check_all("ack_same_cycle", 0);
        do_ack();
        @(negedge clk);
        check_all("ack_clear", 0);

        // Overrun: second word dropped while first is still pending
        send_word(32'h0000001, 1'b0, 1, 1'b0);
        send_word(32'h3FFFFFF, 1'b0, 1, 1'b0);
        check_all("overrun", 0);
        do_ack();
        @(negedge clk);
        check_all("overrun_ack", 0);

        // Frame error: sync re-asserted after 10 bits
        for (int i = 0; i < 10; i++) strobe(1'b1, i == 0, 1'b0);
        @(negedge clk);
        check("frame_midcnt", 32'(bit_count), 32'd10);
        exp_ferr = 1'b1;
        send_word(32'h155, 1'b0, 0, 1'b0);
        check_all("frame", 0);

        // Randomised words with random ack timing and parity corruption
        for (int k = 0; k < 24; k++) begin
            d = $urandom() & MASK;
            a = 1'($urandom_range(0, 1));
            f = PAR ? 1'($urandom_range(0, 1)) : 1'b0;
            send_word(d, a, 2, f);
            check_all("random", 0);
            if ($urandom_range(0, 2) == 0) begin
                do_ack();
                @(negedge clk);
                check_all("random_ack", 0);
            end
        end

        // Asynchronous reset in the middle of a word
        for (int i = 0; i < 13; i++) strobe(1'b1, i == 0, 1'b0);
        @(negedge clk);
        check("mid_cnt", 32'(bit_count), 32'd13);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst", 0);
        @(negedge clk);
        rst = 1'b0;

        // After reset, a fresh word must not carry any of the discarded bits
        send_word(32'h0C0FFEE, 1'b0, 1, 1'b0);
        check_all("post_rst", 0);

`ifdef PARITY_CHECK_EN
        do_ack();
        send_word(32'h0000003, 1'b0, 0, 1'b1);   // parity bit 0
        check_all("parity_bad", 0);
        do_ack();
        send_word(32'h0000003, 1'b0, 0, 1'b0);   // parity bit 1
        check_all("parity_good", 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
